// File: rtl/pipe_adder.sv
// Pipelined add/subtract unit with optional signed saturation, valid/ready flow control on
// both sides and a wrapping completed-transaction counter.
module pipe_adder #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned STAGES  = 2,
    parameter int unsigned COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [1:0]         op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   sum,
    output logic               carry,
    output logic               ovf,
    output logic [COUNT_W-1:0] count
);

    localparam logic [WIDTH-1:0] MaxPos = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0]   b_eff;
    logic [WIDTH:0]     full;
    logic [WIDTH-1:0]   raw;
    logic [WIDTH-1:0]   res;
    logic               res_carry;
    logic               res_ovf;

    logic [STAGES-1:0]  v_q;
    logic [STAGES-1:0]  carry_q;
    logic [STAGES-1:0]  ovf_q;
    logic [WIDTH-1:0]   sum_q [STAGES];
    logic [STAGES-1:0]  ready;
    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] count_d;

    // Subtraction is a + ~b + 1; the carry-out is inverted to report a borrow.
    always_comb begin
        b_eff     = op[0] ? ~b : b;
        full      = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, op[0]};
        raw       = full[WIDTH-1:0];
        res_carry = full[WIDTH] ^ op[0];
        res_ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1]);
        res       = raw;
        if (op[1] && res_ovf) begin
            res = a[WIDTH-1] ? MinNeg : MaxPos;
        end
    end

    // A stage can advance if any stage downstream of it (inclusive) is empty or the sink is ready.
    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            logic free;
            free = out_ready;
            for (int j = i; j < STAGES; j++) begin
                free = free | ~v_q[j];
            end
            ready[i] = free;
        end
    end

    always_comb begin
        count_d = count_q;
        if (out_valid && out_ready) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q     <= '0;
            carry_q <= '0;
            ovf_q   <= '0;
            count_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                sum_q[i] <= '0;
            end
        end else begin
            if (ready[0]) begin
                v_q[0]     <= in_valid;
                sum_q[0]   <= res;
                carry_q[0] <= res_carry;
                ovf_q[0]   <= res_ovf;
            end
            for (int i = 1; i < STAGES; i++) begin
                if (ready[i]) begin
                    v_q[i]     <= v_q[i-1];
                    sum_q[i]   <= sum_q[i-1];
                    carry_q[i] <= carry_q[i-1];
                    ovf_q[i]   <= ovf_q[i-1];
                end
            end
            count_q <= count_d;
        end
    end

    assign in_ready  = ready[0] & rst_n;
    assign out_valid = v_q[STAGES-1];
    assign sum       = sum_q[STAGES-1];
    assign carry     = carry_q[STAGES-1];
    assign ovf       = ovf_q[STAGES-1];
    assign count     = count_q;

endmodule

// File: doc/pipe_adder.md
# pipe_adder

Parametrised, pipelined successor to the single-cycle adder DUT. It performs signed/unsigned add or subtract, with optional signed saturation selected per transaction. A valid/ready handshake on both sides gives full backpressure. It sits behind the same interface/bench harness as the adder, and a completed-transaction counter is provided for bench scoreboarding.

## Interface
Parameters:
- WIDTH, 16, operand/result width in bits (2..64)
- STAGES, 2, pipeline register stages, equal to latency in cycles (1..4)
- COUNT_W, 16, width of completed-transaction counter (1..32)

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk
- in_valid  input  1  operands and op are valid this cycle
- in_ready  output  1  block accepts a transaction this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- op  input  2  operation select: 00 add, 01 sub (a-b), 10 saturating signed add, 11 saturating signed sub
- out_valid  output  1  result fields valid
- out_ready  input  1  downstream accepts the result
- sum  output  WIDTH  result
- carry  output  1  add: unsigned carry-out; sub: unsigned borrow (1 iff a < b unsigned)
- ovf  output  1  signed two's-complement overflow of the unsaturated result
- count  output  COUNT_W  number of output handshakes since reset; wraps modulo 2^COUNT_W

## Operation
- Arithmetic is computed combinationally from a, b, op and captured into stage 1. Stages 2..STAGES only carry {valid, sum, carry, ovf}.
- Internal result is WIDTH+1 bits. For add: {carry, raw} = a + b. For sub: raw = a + ~b + 1, and carry = ~carry-out, i.e. the borrow.
- ovf = (sign a == sign b') && (sign raw != sign a), where b' = b for add and ~b for sub.
- Saturating ops (op[1]=1): if ovf, sum = 2^(WIDTH-1)-1 when a is non-negative, else sum = 2^(WIDTH-1) (the most negative value). Otherwise sum = raw. carry and ovf are reported unchanged in both cases.
- Non-saturating ops: sum = raw.
- Flow control per stage i (i=1 is the input stage, i=STAGES drives the outputs):
  - ready_STAGES = !v_STAGES || out_ready
  - ready_i = !v_i || ready_(i+1)
  - in_ready = ready_1 && rst_n
  - A stage loads from its predecessor when ready_i. Its valid bit becomes the predecessor's valid; stage 1's predecessor valid is in_valid.
- Input handshake: in_valid && in_ready at a rising edge. Output handshake: out_valid && out_ready at a rising edge.
- The counter increments by 1 on each output handshake and wraps from 2^COUNT_W-1 to 0.
- Order is preserved. No transaction is dropped or duplicated except by reset.

## Timing
- Reset (rst_n=0 at a rising edge):
  - all stage valid bits = 0
  - all data registers = 0, so out_valid=0, sum=0, carry=0, ovf=0
  - count=0
  - in_ready=0 while rst_n=0
- First cycle after reset release: in_ready=1.
- Latency: a transaction accepted at edge t with no stalls shows out_valid=1 in the cycle after edge t+STAGES-1, i.e. STAGES cycles after acceptance.
- Throughput: 1 transaction per cycle while out_ready=1.
- Stall: with out_ready=0, in_ready stays 1 until all STAGES stages hold valid data, then drops in the same cycle (combinational path out_ready -> in_ready).
- Simultaneous output handshake and full pipe: with out_ready=1 and the pipe full, in_ready=1 and a new transaction is accepted in the same cycle.
- While out_valid=1 and out_ready=0: sum, carry and ovf hold stable.
- Reset mid-operation: in-flight transactions are discarded. out_valid=0 from the cycle after the reset edge and count returns to 0. No partial result is emitted.
- in_valid while in_ready=0: ignored. The source must hold the operands.

## Test plan
- WIDTH=8, STAGES=3, op=00, a=0x7F, b=0x01 accepted at edge t, out_ready=1 -> out_valid first seen after edge t+2 with sum=0x80, carry=0, ovf=1; count=1 after the handshake.
- Same operands with op=10 -> sum=0x7F, ovf=1, carry=0. Then op=10, a=0xFF, b=0x01 -> sum=0x00, carry=1, ovf=0.
- op=01, a=0x00, b=0x01 -> sum=0xFF, carry=1, ovf=0. Then op=11, a=0x80, b=0x01 -> sum=0x80 (saturated), ovf=1, carry=0.
- Backpressure: issue 5 back-to-back ops with out_ready=0 for 4 cycles -> in_ready falls after 3 accepts and the first result holds stable. After out_ready=1, all 5 results emerge in order with no gaps or duplicates, and count=5.
- Reset mid-operation: 2 transactions in flight, rst_n=0 for one edge -> out_valid=0, sum=0, count=0 in the next cycle, and neither result ever appears. A fresh op then completes with normal latency.
- Counter wrap with COUNT_W=4: complete 17 transactions -> count goes 15 -> 0 on the 16th and reads 1 after the 17th.
